sha1_pre_seq: RTL and testbench
===============================

Name: sha1_pre_seq

Overview:
- Folded, parametrised successor of the unrolled per-round SHA-1 pre-add stage.
- Accepts one 512-bit message window through a valid/ready handshake.
- Emits one round per step: P[r] = W[r] + K(r) + d_in, the e-replacement term for the compression core, for a configurable contiguous run of rounds. The W schedule is generated in place by a 16-word shift window.
- Sits between the message source and an iterative compression core. It supports output backpressure and hands off the final window so blocks can be chained.

Parameters:
- START_ROUND, 0, first round index processed (0..79); msg_in holds W[START_ROUND..START_ROUND+15].
- NUM_ROUNDS, 80, rounds processed per accepted block (1..80-START_ROUND).
- ROUND_W, 7, width of round index outputs.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  msg_in valid
- in_ready  out  1  block can accept a message (IDLE only)
- msg_in  in  512  window; word j = bits [32j+31:32j] = W[START_ROUND+j]
- abort  in  1  synchronous flush to IDLE, ignores handshake
- d_in  in  32  D[r-1] from compression core, sampled on each step
- out_valid  out  1  p_out/w_out/round_out valid
- out_ready  in  1  downstream accepts current output
- p_out  out  32  W[r]+K(r)+d_in mod 2^32
- w_out  out  32  W[r]
- round_out  out  ROUND_W  r
- last  out  1  r == START_ROUND+NUM_ROUNDS-1
- win_out  out  512  window after final shift, valid while last && out_valid

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, out_valid=0, last=0, p_out=0, w_out=0, round_out=0, win_out=0, window=0, counter=0. Reset overrides abort and every handshake.
- Reset mid-RUN discards the block. No output is produced until the next accept.
- States and transitions:
  - IDLE: in_ready=1. On in_valid: load window<=msg_in, r<=START_ROUND, go to RUN.
  - RUN: in_ready=0. A step fires when (!out_valid || out_ready). No step fires while out_valid && !out_ready; then all outputs and d_in sampling hold.
  - RUN, step on the final round: go to DRAIN.
  - DRAIN: in_ready=0, outputs hold. When out_ready, out_valid<=0 and go to IDLE. A new accept is possible the following cycle.
- Step, all registered:
  - p_out <= window[0] + K(r) + d_in, 32-bit wrap.
  - w_out <= window[0], round_out <= r, last <= (r==end), out_valid <= 1.
  - window <= {rotl1(w[13]^w[8]^w[2]^w[0]), window[15:1]}, i.e. word0 discarded, new word at word15.
  - r <= r+1.
- K(r): r<20 → 5A827999, r<40 → 6ED9EBA1, r<60 → 8F1BBCDC, else CA62C1D6.
- Latency: first output appears one cycle after the first step edge. Throughput is 1 round/cycle with out_ready held high. NUM_ROUNDS outputs per block, then one DRAIN handshake.
- In RUN, if out_ready is seen on the cycle of a step, the old output is consumed and the new one is loaded in the same edge. No bubble.
- In RUN, out_valid falls only on abort or reset.
- win_out <= the shifted window on the last step; it holds until the next accept.
- abort=1: state<=IDLE, out_valid<=0, last<=0. Data registers are unchanged. abort in IDLE with in_valid=1: no accept.
- NUM_ROUNDS=1: RUN lasts one step and goes directly to DRAIN.
- START_ROUND+NUM_ROUNDS>80: elaboration-time error.
- Output contract: never change p_out/w_out/round_out/last while out_valid && !out_ready.

Decomposition:
- Shared package sha1_pkg:
  - K constants SHA1_K0..K3.
  - function sha1_k(round).
  - function rotl1.
  - localparams SHA1_ROUNDS=80, SHA1_WORDS=16.
- One sub-module, sha1_w_window: 16x32 shift window. Inputs load, shift, msg_in. Outputs w_cur, win. It computes the recurrence internally.
- FSM, counter and P adder live in the top.

Test Plan:
- "abc" padded block (W0=61626380, W15=00000018, others 0), START_ROUND=0, d_in=C3D2E1F0 at r=0, out_ready=1 → first p_out=7FB7BF09, w_out=61626380, round_out=0. Count 80 outputs. last only on round 79.
- Same block, d_in=0 → r=16 gives w_out=C2C4C700, p_out=1D474099. r=20 with all-zero msg gives p_out=6ED9EBA1. K switches at 20/40/60 verified.
- Backpressure: out_ready toggled 1,0,0,1 pseudo-randomly → outputs hold stable when stalled. No round skipped or duplicated. d_in sampled only on step cycles.
- abort asserted at r=37 → out_valid=0 next cycle, in_ready=1. A fresh block then restarts at round_out=START_ROUND.
- rst_n low for one cycle mid-RUN → all outputs 0, state IDLE. in_valid held high → accept on the first cycle after reset release.
- START_ROUND=16, NUM_ROUNDS=1, msg_in=W[16..31] of "abc" → single output round_out=16, last=1, p_out matches the case-2 value with d_in=0. win_out = window shifted once. in_ready=0 until out_ready is seen in DRAIN.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: round constants, schedule helpers and the
// sequencer state encoding used by the folded pre-add stage.
package sha1_pkg;

  localparam int SHA1_ROUNDS = 80;
  localparam int SHA1_WORDS  = 16;

  localparam logic [31:0] SHA1_K0 = 32'h5A827999;
  localparam logic [31:0] SHA1_K1 = 32'h6ED9EBA1;
  localparam logic [31:0] SHA1_K2 = 32'h8F1BBCDC;
  localparam logic [31:0] SHA1_K3 = 32'hCA62C1D6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pre_state_e;

  function automatic logic [31:0] sha1_k(input logic [6:0] round);
    logic [31:0] k_s;
    if (round < 7'd20) begin
      k_s = SHA1_K0;
    end else if (round < 7'd40) begin
      k_s = SHA1_K1;
    end else if (round < 7'd60) begin
      k_s = SHA1_K2;
    end else begin
      k_s = SHA1_K3;
    end
    return k_s;
  endfunction

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

endpackage

// File: rtl/sha1_w_window.sv
// 16-word SHA-1 message schedule window; word 0 is the current W[r] and each
// shift appends the next schedule word at word 15.
module sha1_w_window
  import sha1_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       shift,
  input  logic [SHA1_WORDS*32-1:0]   msg_in,
  output logic [31:0]                w_cur,
  output logic [SHA1_WORDS*32-1:0]   win
);

  logic [SHA1_WORDS*32-1:0] window_r;
  logic [31:0]              new_word_s;
  logic [SHA1_WORDS*32-1:0] win_nxt_s;

  // W[t] = rotl1(W[t-3] ^ W[t-8] ^ W[t-14] ^ W[t-16]) relative to a window based at t-16
  assign new_word_s = rotl1(window_r[13*32 +: 32] ^ window_r[8*32 +: 32] ^
                            window_r[2*32 +: 32]  ^ window_r[0 +: 32]);
  assign win_nxt_s  = {new_word_s, window_r[SHA1_WORDS*32-1:32]};

  // Window register: load a fresh block, shift one round, or hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window_r <= '0;
    end else if (load) begin
      window_r <= msg_in;
    end else if (shift) begin
      window_r <= win_nxt_s;
    end else begin
      window_r <= window_r;
    end
  end

  assign w_cur = window_r[31:0];
  // win is the window as it will look after the next shift
  assign win   = win_nxt_s;

endmodule

// File: rtl/sha1_pre_seq.sv
// Folded SHA-1 pre-add stage: one round per step emits P[r] = W[r] + K(r) + d_in
// with output backpressure and a final-window handoff for block chaining.
module sha1_pre_seq
  import sha1_pkg::*;
#(
  parameter int START_ROUND = 0,
  parameter int NUM_ROUNDS  = 80,
  parameter int ROUND_W     = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [511:0]       msg_in,
  input  logic               abort,
  input  logic [31:0]        d_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        p_out,
  output logic [31:0]        w_out,
  output logic [ROUND_W-1:0] round_out,
  output logic               last,
  output logic [511:0]       win_out
);

  localparam int END_ROUND = START_ROUND + NUM_ROUNDS - 1;
  localparam logic [ROUND_W-1:0] START_R = ROUND_W'(START_ROUND);
  localparam logic [ROUND_W-1:0] END_R   = ROUND_W'(END_ROUND);

  generate
    if (START_ROUND < 0 || START_ROUND >= SHA1_ROUNDS || NUM_ROUNDS < 1 ||
        START_ROUND + NUM_ROUNDS > SHA1_ROUNDS || END_ROUND >= (1 << ROUND_W)) begin : g_bad_params
      $error("sha1_pre_seq: round range exceeds 0..79 or ROUND_W too narrow");
    end
  endgenerate

  pre_state_e         state_r;
  pre_state_e         state_nxt_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               last_r;
  logic [31:0]        p_out_r;
  logic [31:0]        w_out_r;
  logic [ROUND_W-1:0] round_out_r;
  logic [ROUND_W-1:0] round_cnt_r;
  logic [511:0]       win_out_r;

  logic               accept_s;
  logic               step_s;
  logic               drain_done_s;
  logic               final_s;
  logic [31:0]        w_cur_s;
  logic [31:0]        p_s;
  logic [511:0]       win_nxt_s;

  sha1_w_window u_window (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept_s),
    .shift  (step_s),
    .msg_in (msg_in),
    .w_cur  (w_cur_s),
    .win    (win_nxt_s)
  );

  // State register; in_ready is registered from the next state so it tracks IDLE exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == ST_IDLE);
    end
  end

  // Next-state logic; abort wins over every handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (step_s && final_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort || out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Control strobes; a step only fires when the output slot is free or being consumed.
  always_comb begin
    final_s      = (round_cnt_r == END_R);
    accept_s     = (state_r == ST_IDLE) && in_valid && !abort;
    step_s       = (state_r == ST_RUN) && !abort && (!out_valid_r || out_ready);
    drain_done_s = (state_r == ST_DRAIN) && !abort && out_ready;
  end

  assign p_s = w_cur_s + sha1_k(7'(round_cnt_r)) + d_in;

  // Round counter: restarts on accept, advances once per step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      round_cnt_r <= '0;
    end else if (accept_s) begin
      round_cnt_r <= START_R;
    end else if (step_s) begin
      round_cnt_r <= round_cnt_r + ROUND_W'(1);
    end else begin
      round_cnt_r <= round_cnt_r;
    end
  end

  // Output registers; abort only drops the valid/last flags and leaves data in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      last_r      <= 1'b0;
      p_out_r     <= 32'd0;
      w_out_r     <= 32'd0;
      round_out_r <= '0;
      win_out_r   <= 512'd0;
    end else if (abort) begin
      out_valid_r <= 1'b0;
      last_r      <= 1'b0;
    end else if (step_s) begin
      out_valid_r <= 1'b1;
      last_r      <= final_s;
      p_out_r     <= p_s;
      w_out_r     <= w_cur_s;
      round_out_r <= round_cnt_r;
      if (final_s) begin
        win_out_r <= win_nxt_s;
      end else begin
        win_out_r <= win_out_r;
      end
    end else if (drain_done_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign p_out     = p_out_r;
  assign w_out     = w_out_r;
  assign round_out = round_out_r;
  assign last      = last_r;
  assign win_out   = win_out_r;

endmodule

// File: tb/tb_sha1_pre_seq.sv
// Directed bench for sha1_pre_seq: hand-computed vector table plus a cycle
// model for streaming, backpressure, abort, reset and single-round cases.
module tb_sha1_pre_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, abort, out_ready;
  logic [511:0] msg_in;
  logic [31:0]  d_in;
  logic         in_ready, out_valid, last;
  logic [31:0]  p_out, w_out;
  logic [6:0]   round_out;
  logic [511:0] win_out;

  logic         in_valid1, abort1, out_ready1;
  logic [511:0] msg_in1;
  logic [31:0]  d_in1;
  logic         in_ready1, out_valid1, last1;
  logic [31:0]  p_out1, w_out1;
  logic [6:0]   round_out1;
  logic [511:0] win_out1;

  sha1_pre_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .msg_in(msg_in),
    .abort(abort), .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready), .p_out(p_out),
    .w_out(w_out), .round_out(round_out), .last(last), .win_out(win_out)
  );

  sha1_pre_seq #(.START_ROUND(16), .NUM_ROUNDS(1), .ROUND_W(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .msg_in(msg_in1),
    .abort(abort1), .d_in(d_in1), .out_valid(out_valid1), .out_ready(out_ready1), .p_out(p_out1),
    .w_out(w_out1), .round_out(round_out1), .last(last1), .win_out(win_out1)
  );

  typedef struct {
    int          blk;
    int          r;
    logic [31:0] w;
    logic [31:0] p;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [31:0]  wm [0:95];
  logic [31:0]  cap_p [0:1][0:79];
  logic [31:0]  cap_w [0:1][0:79];
  int           st_m, nr, dmode, blk, n_hs;
  logic         mv, e_last;
  logic [6:0]   e_r;
  logic [31:0]  e_p, e_w;
  logic [511:0] e_win;

  localparam logic [511:0] MSG_ABC  = {32'h00000018, 448'd0, 32'h61626380};
  localparam logic [511:0] MSG_ZERO = 512'd0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] kf(input int r);
    if (r < 20) return 32'h5A827999;
    else if (r < 40) return 32'h6ED9EBA1;
    else if (r < 60) return 32'h8F1BBCDC;
    else return 32'hCA62C1D6;
  endfunction

  function automatic logic [31:0] dfun(input int r);
    if (dmode == 0) return (r == 0) ? 32'hC3D2E1F0 : 32'h0;
    else if (dmode == 1) return 32'h0;
    else return (32'(r) * 32'h01000193) ^ 32'h9E3779B9;
  endfunction

  task automatic build_sched(input logic [511:0] m);
    for (int j = 0; j < 16; j++) wm[j] = m[32*j +: 32];
    for (int t = 16; t < 96; t++) wm[t] = rl1(wm[t-3] ^ wm[t-8] ^ wm[t-14] ^ wm[t-16]);
    for (int j = 0; j < 16; j++) e_win[32*j +: 32] = wm[80+j];
  endtask

  // One clock of stimulus for the default instance: check what is visible now,
  // drive inputs for the coming edge, advance the model across that edge.
  task automatic cycle(input logic rdy, input logic ab, input logic iv);
    logic [31:0] d;
    chk("out_valid", out_valid, mv);
    chk("in_ready", in_ready, st_m == 0);
    if (mv) begin
      chk("round_out", round_out, e_r);
      chk("w_out", w_out, e_w);
      chk("p_out", p_out, e_p);
      chk("last", last, e_last);
      if (e_last) chk("win_out", win_out, e_win);
      if (blk >= 0 && round_out < 7'd80) begin
        cap_p[blk][round_out] = p_out;
        cap_w[blk][round_out] = w_out;
      end
    end
    if (out_valid && rdy && !ab) n_hs++;
    out_ready = rdy;
    abort     = ab;
    in_valid  = iv;
    d_in      = $urandom();
    if (ab) begin
      mv   = 1'b0;
      st_m = 0;
    end else if (st_m == 0) begin
      if (iv) begin
        st_m = 1;
        nr   = 0;
      end
    end else if (st_m == 1) begin
      if (!mv || rdy) begin
        d      = dfun(nr);
        d_in   = d;
        e_r    = 7'(nr);
        e_w    = wm[nr];
        e_p    = wm[nr] + kf(nr) + d;
        e_last = (nr == 79);
        mv     = 1'b1;
        nr++;
        if (e_last) st_m = 2;
      end
    end else begin
      if (rdy) begin
        mv   = 1'b0;
        st_m = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_rest(input bit bp, input int abort_at);
    logic rdy, ab;
    for (int c = 0; c < 600 && st_m != 0; c++) begin
      ab  = (abort_at >= 0) && mv && (st_m == 1) && (int'(e_r) == abort_at);
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(rdy, ab, 1'b0);
    end
    checks++;
    if (st_m != 0) begin
      errors++;
      $display("FAIL block_timeout: got state %0d expected 0", st_m);
    end
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_block(input logic [511:0] m, input int dm, input int b, input bit bp,
                           input int abort_at);
    build_sched(m);
    msg_in = m;
    dmode  = dm;
    blk    = b;
    n_hs   = 0;
    cycle(1'b1, 1'b0, 1'b1);
    run_rest(bp, abort_at);
    if (abort_at < 0) chk("handshakes", 32'(n_hs), 32'd80);
  endtask

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{0, 0,  32'h61626380, 32'h7FB7BF09};
    tbl[1]  = '{0, 1,  32'h00000000, 32'h5A827999};
    tbl[2]  = '{0, 15, 32'h00000018, 32'h5A8279B1};
    tbl[3]  = '{0, 16, 32'hC2C4C700, 32'h1D474099};
    tbl[4]  = '{0, 18, 32'h00000030, 32'h5A8279C9};
    tbl[5]  = '{0, 19, 32'h85898E01, 32'hE00C079A};
    tbl[6]  = '{0, 21, 32'h00000060, 32'h6ED9EC01};
    tbl[7]  = '{0, 22, 32'h0B131C03, 32'h79ED07A4};
    tbl[8]  = '{0, 23, 32'h00000030, 32'h6ED9EBD1};
    tbl[9]  = '{1, 0,  32'h00000000, 32'h5A827999};
    tbl[10] = '{1, 19, 32'h00000000, 32'h5A827999};
    tbl[11] = '{1, 20, 32'h00000000, 32'h6ED9EBA1};
    tbl[12] = '{1, 39, 32'h00000000, 32'h6ED9EBA1};
    tbl[13] = '{1, 40, 32'h00000000, 32'h8F1BBCDC};
    tbl[14] = '{1, 59, 32'h00000000, 32'h8F1BBCDC};
    tbl[15] = '{1, 60, 32'h00000000, 32'hCA62C1D6};
    tbl[16] = '{1, 79, 32'h00000000, 32'hCA62C1D6};
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 80; r++) begin
        cap_p[b][r] = 32'hDEADBEEF;
        cap_w[b][r] = 32'hDEADBEEF;
      end

    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1; msg_in = '0; d_in = '0;
    in_valid1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b1; msg_in1 = '0; d_in1 = '0;
    st_m = 0; mv = 1'b0; nr = 0; blk = -1; dmode = 1; n_hs = 0;
    e_last = 1'b0; e_r = '0; e_p = '0; e_w = '0; e_win = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst p_out", p_out, 32'd0);
    chk("rst round_out", round_out, 7'd0);
    chk("rst win_out", win_out, 512'd0);

    // Single-round instance starting at round 16 of the "abc" schedule.
    build_sched(MSG_ABC);
    for (int j = 0; j < 16; j++) msg_in1[32*j +: 32] = wm[16+j];
    in_valid1 = 1'b1;
    chk("r16 in_ready idle", in_ready1, 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid1 = 1'b0; out_ready1 = 1'b0; d_in1 = 32'd0;
    chk("r16 no early output", out_valid1, 1'b0);
    chk("r16 in_ready run", in_ready1, 1'b0);
    @(posedge clk); @(negedge clk);
    d_in1 = 32'h12345678;
    chk("r16 out_valid", out_valid1, 1'b1);
    chk("r16 round_out", round_out1, 7'd16);
    chk("r16 last", last1, 1'b1);
    chk("r16 p_out", p_out1, 32'h1D474099);
    chk("r16 w_out", w_out1, 32'hC2C4C700);
    for (int j = 0; j < 16; j++) chk("r16 win_out word", win_out1[32*j +: 32], wm[17+j]);
    @(posedge clk); @(negedge clk);
    chk("r16 drain hold valid", out_valid1, 1'b1);
    chk("r16 drain hold p_out", p_out1, 32'h1D474099);
    chk("r16 drain in_ready", in_ready1, 1'b0);
    out_ready1 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("r16 drained valid", out_valid1, 1'b0);
    chk("r16 drained in_ready", in_ready1, 1'b1);

    run_block(MSG_ABC, 0, 0, 1'b0, -1);
    run_block(MSG_ZERO, 1, 1, 1'b0, -1);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("tbl w blk%0d r%0d", tbl[i].blk, tbl[i].r), cap_w[tbl[i].blk][tbl[i].r], tbl[i].w);
      chk($sformatf("tbl p blk%0d r%0d", tbl[i].blk, tbl[i].r), cap_p[tbl[i].blk][tbl[i].r], tbl[i].p);
    end

    run_block(MSG_ABC, 2, -1, 1'b1, -1);
    run_block(MSG_ABC, 2, -1, 1'b0, 37);
    run_block(MSG_ZERO, 2, -1, 1'b1, -1);

    // Reset mid-run with in_valid held high: accept on the first cycle after release.
    build_sched(MSG_ABC);
    msg_in = MSG_ABC; dmode = 2; blk = -1;
    cycle(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) cycle(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0; in_valid = 1'b1; abort = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; mv = 1'b0; st_m = 0;
    chk("mrst out_valid", out_valid, 1'b0);
    chk("mrst p_out", p_out, 32'd0);
    chk("mrst w_out", w_out, 32'd0);
    chk("mrst round_out", round_out, 7'd0);
    chk("mrst last", last, 1'b0);
    chk("mrst win_out", win_out, 512'd0);
    n_hs = 0;
    cycle(1'b1, 1'b0, 1'b1);
    run_rest(1'b0, -1);
    chk("mrst handshakes", 32'(n_hs), 32'd80);

    // Abort in IDLE with in_valid high must not accept.
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    run_block(MSG_ABC, 0, -1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
